// File: rtl/simple_fixed_point_long_division.sv
// Pipelined unsigned divider: {dividend,4'b0} / divisor -> Q4.4 quotient.
// One restoring long-division step per stage, new operand pair every clock.
module simple_fixed_point_long_division (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAC_BITS = 4;
  localparam int unsigned OP_W      = WIDTH - FRAC_BITS;
  localparam int unsigned STAGES    = WIDTH;

  // Stage s performs step i = WIDTH-1-s; numerator bits shrink and quotient bits grow per stage.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned IN_W = WIDTH - s;

    logic [OP_W-1:0] rem_in;
    logic [OP_W-1:0] den_in;
    logic [IN_W-1:0] num_in;
    logic            vld_in;
    logic [OP_W:0]   trial;
    logic            take;
    logic [s:0]      quo_nxt;
    logic [s:0]      quo_q;
    logic            vld_q;

    if (s == 0) begin : g_src
      assign rem_in  = '0;
      assign den_in  = data_in[OP_W-1:0];
      assign num_in  = {data_in[WIDTH-1:OP_W], {FRAC_BITS{1'b0}}};
      assign vld_in  = 1'b1;
      assign quo_nxt = take;
    end else begin : g_src
      assign rem_in  = g_stage[s-1].g_hold.rem_q;
      assign den_in  = g_stage[s-1].g_hold.den_q;
      assign num_in  = g_stage[s-1].g_hold.num_q;
      assign vld_in  = g_stage[s-1].vld_q;
      assign quo_nxt = {g_stage[s-1].quo_q, take};
    end

    // Previous remainder is always below D, so its low OP_W bits carry all of it.
    assign trial = {rem_in, num_in[IN_W-1]};
    assign take  = (trial >= {1'b0, den_in});

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        quo_q <= '0;
        vld_q <= 1'b0;
      end else begin
        quo_q <= quo_nxt;
        vld_q <= vld_in;
      end
    end

    // The final stage has no successor, so only its quotient and valid are kept.
    if (s < STAGES - 1) begin : g_hold
      logic [OP_W-1:0] rem_q;
      logic [OP_W-1:0] den_q;
      logic [IN_W-2:0] num_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rem_q <= '0;
          den_q <= '0;
          num_q <= '0;
        end else begin
          rem_q <= take ? OP_W'(trial - {1'b0, den_in}) : trial[OP_W-1:0];
          den_q <= den_in;
          num_q <= num_in[IN_W-2:0];
        end
      end
    end
  end

  // Output register only advances once the pipeline has produced a real result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (g_stage[STAGES-1].vld_q) begin
      data_out <= g_stage[STAGES-1].quo_q;
    end
  end

endmodule

// File: tb/tb_simple_fixed_point_long_division.sv
// Directed bench for the pipelined Q4.4 divider: reset/fill, truncation,
// extremes, streaming, mid-stream reset and a full sweep of data_in.
module tb_simple_fixed_point_long_division;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] FILL   = 8'h11;
  localparam logic [7:0] FILL_Q = 8'h10;

  simple_fixed_point_long_division dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Reference: floor(a*16/d), saturated to 0xFF for d = 0.
  function automatic logic [7:0] ref_q(input logic [7:0] v);
    int unsigned a;
    int unsigned d;
    a = 32'(v[7:4]);
    d = 32'(v[3:0]);
    if (d == 0) return 8'hFF;
    return 8'((a * 16) / d);
  endfunction

  task automatic prime(input logic [7:0] v);
    for (int i = 0; i < 9; i++) begin
      data_in = v;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    data_in = 8'h63;
    #1;
    total++;
    if (data_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", data_out, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (data_out !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, data_out, 8'h00);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if (data_out !== 8'h00) begin
        bad++;
        $display("FAIL fill_edge%0d got=%h want=%h", i, data_out, 8'h00);
      end
    end
    @(negedge clk);
    total++;
    if (data_out !== 8'h20) begin
      bad++;
      $display("FAIL first_result got=%h want=%h", data_out, 8'h20);
    end
  endtask

  task automatic test_fraction;
    logic [7:0] vin [2];
    logic [7:0] vex [2];
    vin[0] = 8'h73; vex[0] = 8'h25;
    vin[1] = 8'h1F; vex[1] = 8'h01;
    for (int t = 0; t < 2; t++) begin
      prime(FILL);
      data_in = vin[t];
      @(negedge clk);
      data_in = FILL;
      repeat (7) @(negedge clk);
      total++;
      if (data_out !== FILL_Q) begin
        bad++;
        $display("FAIL frac_early in=%h got=%h want=%h", vin[t], data_out, FILL_Q);
      end
      @(negedge clk);
      total++;
      if (data_out !== vex[t]) begin
        bad++;
        $display("FAIL frac_result in=%h got=%h want=%h", vin[t], data_out, vex[t]);
      end
      @(negedge clk);
      total++;
      if (data_out !== FILL_Q) begin
        bad++;
        $display("FAIL frac_after in=%h got=%h want=%h", vin[t], data_out, FILL_Q);
      end
    end
  endtask

  task automatic test_extremes;
    logic [7:0] vin [3];
    logic [7:0] vex [3];
    vin[0] = 8'hF1; vex[0] = 8'hF0;
    vin[1] = 8'h0A; vex[1] = 8'h00;
    vin[2] = 8'h50; vex[2] = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      prime(FILL);
      data_in = vin[t];
      @(negedge clk);
      data_in = FILL;
      repeat (7) @(negedge clk);
      total++;
      if (data_out !== FILL_Q) begin
        bad++;
        $display("FAIL ext_early in=%h got=%h want=%h", vin[t], data_out, FILL_Q);
      end
      @(negedge clk);
      total++;
      if (data_out !== vex[t]) begin
        bad++;
        $display("FAIL ext_result in=%h got=%h want=%h", vin[t], data_out, vex[t]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vin [5];
    logic [7:0] vex [5];
    vin[0] = 8'h63; vex[0] = 8'h20;
    vin[1] = 8'h73; vex[1] = 8'h25;
    vin[2] = 8'hF1; vex[2] = 8'hF0;
    vin[3] = 8'h50; vex[3] = 8'hFF;
    vin[4] = 8'h84; vex[4] = 8'h20;
    prime(FILL);
    for (int c = 0; c < 14; c++) begin
      data_in = (c < 5) ? vin[c] : FILL;
      @(negedge clk);
      if (c >= 8 && c < 13) begin
        total++;
        if (data_out !== vex[c-8]) begin
          bad++;
          $display("FAIL stream[%0d] got=%h want=%h", c - 8, data_out, vex[c-8]);
        end
      end else if (c == 13 || c == 7) begin
        total++;
        if (data_out !== FILL_Q) begin
          bad++;
          $display("FAIL stream_edge c=%0d got=%h want=%h", c, data_out, FILL_Q);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    prime(8'h73);
    total++;
    if (data_out !== 8'h25) begin
      bad++;
      $display("FAIL mrst_full got=%h want=%h", data_out, 8'h25);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (data_out !== 8'h00) begin
      bad++;
      $display("FAIL mrst_async got=%h want=%h", data_out, 8'h00);
    end
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    data_in = 8'hF1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if (data_out !== 8'h00) begin
        bad++;
        $display("FAIL mrst_fill_edge%0d got=%h want=%h", i, data_out, 8'h00);
      end
    end
    @(negedge clk);
    total++;
    if (data_out !== 8'hF0) begin
      bad++;
      $display("FAIL mrst_first got=%h want=%h", data_out, 8'hF0);
    end
  endtask

  task automatic test_exhaustive;
    logic [7:0] want;
    for (int c = 0; c < 256 + 8; c++) begin
      data_in = (c < 256) ? 8'(c) : FILL;
      @(negedge clk);
      if (c >= 8) begin
        want = ref_q(8'(c - 8));
        total++;
        if (data_out !== want) begin
          bad++;
          $display("FAIL sweep in=%h got=%h want=%h", 8'(c - 8), data_out, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fraction();
    test_extremes();
    test_back_to_back();
    test_mid_reset();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
